// File: rtl/fifo_a2b_channel.sv
// FIFO channel between producer A and consumer B, with four method calls.
// Each call uses a req/busy handshake: enque, deque, is_finished, check_finished.
module fifo_a2b_channel #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 4,
  parameter int DEPTH  = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     ce,
  input  logic                     i_enque_req,
  input  logic signed [DWIDTH-1:0] i_enque_n_in,
  output logic                     o_enque_busy,
  input  logic                     i_deque_req,
  output logic                     o_deque_busy,
  output logic signed [DWIDTH-1:0] o_deque_return,
  input  logic                     i_is_finished_req,
  input  logic                     i_is_finished_in_finished,
  output logic                     o_is_finished_busy,
  input  logic                     i_check_finished_req,
  output logic                     o_check_finished_busy,
  output logic                     o_check_finished_return
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} call_state_e;

  localparam logic [AWIDTH:0] FULL_COUNT = (AWIDTH + 1)'(DEPTH);

  call_state_e enq_state, deq_state, isf_state, chk_state;

  logic signed [DWIDTH-1:0] mem [DEPTH];
  logic        [AWIDTH-1:0] wr_ptr, rd_ptr;
  logic        [AWIDTH:0]   count;
  logic signed [DWIDTH-1:0] enq_data;
  logic                     fin_data;
  logic                     finished;
  logic                     enq_done, deq_done;

  // Both conditions look at the pre-edge count, so full+deque and
  // empty+enque each let one side through and stall the other for a cycle.
  assign enq_done = (enq_state == ACTIVE) && (count < FULL_COUNT);
  assign deq_done = (deq_state == ACTIVE) && (count != '0);

  assign o_enque_busy          = (enq_state == ACTIVE);
  assign o_deque_busy          = (deq_state == ACTIVE);
  assign o_is_finished_busy    = (isf_state == ACTIVE);
  assign o_check_finished_busy = (chk_state == ACTIVE);

  // NOTE: storage is not reset; count and the pointers already mark every
  // entry invalid, and leaving it out keeps the array mappable onto RAM.
  always_ff @(posedge clock) begin
    if (ce && enq_done) mem[wr_ptr] <= enq_data;
  end

  // NOTE: all state updates use non-blocking assignments, so every condition
  // below sees pre-edge values. check_finished relies on this and returns the
  // old flag when is_finished completes on the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      enq_state               <= IDLE;
      deq_state               <= IDLE;
      isf_state               <= IDLE;
      chk_state               <= IDLE;
      wr_ptr                  <= '0;
      rd_ptr                  <= '0;
      count                   <= '0;
      enq_data                <= '0;
      fin_data                <= 1'b0;
      finished                <= 1'b0;
      o_deque_return          <= '0;
      o_check_finished_return <= 1'b0;
    end else if (ce) begin
      case (enq_state)
        IDLE: if (i_enque_req) begin
          enq_state <= ACTIVE;
          enq_data  <= i_enque_n_in;
        end
        ACTIVE: if (enq_done) begin
          wr_ptr    <= wr_ptr + 1'b1;
          enq_state <= IDLE;
        end
        default: enq_state <= IDLE;
      endcase

      case (deq_state)
        IDLE: if (i_deque_req) deq_state <= ACTIVE;
        ACTIVE: if (deq_done) begin
          o_deque_return <= mem[rd_ptr];
          rd_ptr         <= rd_ptr + 1'b1;
          deq_state      <= IDLE;
        end
        default: deq_state <= IDLE;
      endcase

      case (isf_state)
        IDLE: if (i_is_finished_req) begin
          isf_state <= ACTIVE;
          fin_data  <= i_is_finished_in_finished;
        end
        ACTIVE: begin
          finished  <= fin_data;
          isf_state <= IDLE;
        end
        default: isf_state <= IDLE;
      endcase

      case (chk_state)
        IDLE: if (i_check_finished_req) chk_state <= ACTIVE;
        ACTIVE: begin
          o_check_finished_return <= finished;
          chk_state               <= IDLE;
        end
        default: chk_state <= IDLE;
      endcase

      case ({enq_done, deq_done})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_a2b_channel.sv
// Self-checking bench for fifo_a2b_channel: directed scenarios plus a random
// sequence of method calls checked against a queue-based reference model.
module tb_fifo_a2b_channel;
  localparam int DWIDTH = 32;
  localparam int AWIDTH = 4;
  localparam int DEPTH  = 16;
  localparam int BOUND  = 50;

  logic                     clock = 1'b0;
  logic                     reset_n = 1'b0;
  logic                     ce = 1'b1;
  logic                     enq_req = 1'b0;
  logic signed [DWIDTH-1:0] enq_in = '0;
  logic                     enq_busy;
  logic                     deq_req = 1'b0;
  logic                     deq_busy;
  logic signed [DWIDTH-1:0] deq_ret;
  logic                     isf_req = 1'b0;
  logic                     isf_in = 1'b0;
  logic                     isf_busy;
  logic                     chk_req = 1'b0;
  logic                     chk_busy;
  logic                     chk_ret;

  int tests_run = 0;
  int tests_failed = 0;

  logic signed [DWIDTH-1:0] model_q[$];
  logic                     model_flag = 1'b0;

  fifo_a2b_channel #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .DEPTH(DEPTH)) dut (
    .clock                    (clock),
    .reset_n                  (reset_n),
    .ce                       (ce),
    .i_enque_req              (enq_req),
    .i_enque_n_in             (enq_in),
    .o_enque_busy             (enq_busy),
    .i_deque_req              (deq_req),
    .o_deque_busy             (deq_busy),
    .o_deque_return           (deq_ret),
    .i_is_finished_req        (isf_req),
    .i_is_finished_in_finished(isf_in),
    .o_is_finished_busy       (isf_busy),
    .i_check_finished_req     (chk_req),
    .o_check_finished_busy    (chk_busy),
    .o_check_finished_return  (chk_ret)
  );

  always #5 clock = ~clock;

  task automatic do_enque(input logic signed [DWIDTH-1:0] v, output int cycles);
    @(negedge clock); enq_req = 1'b1; enq_in = v;
    @(negedge clock); enq_req = 1'b0;
    cycles = 0;
    while (enq_busy === 1'b1 && cycles < BOUND) begin @(negedge clock); cycles++; end
    model_q.push_back(v);
  endtask

  task automatic do_deque(output logic signed [DWIDTH-1:0] v, output int cycles);
    @(negedge clock); deq_req = 1'b1;
    @(negedge clock); deq_req = 1'b0;
    cycles = 0;
    while (deq_busy === 1'b1 && cycles < BOUND) begin @(negedge clock); cycles++; end
    v = deq_ret;
  endtask

  task automatic do_set_finished(input logic f, output int cycles);
    @(negedge clock); isf_req = 1'b1; isf_in = f;
    @(negedge clock); isf_req = 1'b0;
    cycles = 0;
    while (isf_busy === 1'b1 && cycles < BOUND) begin @(negedge clock); cycles++; end
    model_flag = f;
  endtask

  task automatic do_check_finished(output logic r, output int cycles);
    @(negedge clock); chk_req = 1'b1;
    @(negedge clock); chk_req = 1'b0;
    cycles = 0;
    while (chk_busy === 1'b1 && cycles < BOUND) begin @(negedge clock); cycles++; end
    r = chk_ret;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({enq_busy, deq_busy, isf_busy, chk_busy, chk_ret} !== 5'b0 || deq_ret !== '0 ||
        dut.count !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b%b%b%b chk_ret=%b deq_ret=%0d count=%0d, required all 0",
               enq_busy, deq_busy, isf_busy, chk_busy, chk_ret, deq_ret, dut.count);
    end
  endtask

  task automatic test_basic();
    int cyc;
    logic signed [DWIDTH-1:0] v, exp;
    for (int i = 5; i <= 7; i++) begin
      do_enque(i, cyc);
      tests_run++;
      if (cyc !== 1) begin
        tests_failed++; $display("FAIL basic_enque_busy: got %0d cycles, required 1", cyc);
      end
    end
    for (int i = 0; i < 3; i++) begin
      do_deque(v, cyc);
      exp = model_q.pop_front();
      tests_run++;
      if (v !== exp || cyc !== 1) begin
        tests_failed++;
        $display("FAIL basic_deque: got %0d (%0d cycles), required %0d (1 cycle)", v, cyc, exp);
      end
    end
    tests_run++;
    if (dut.count !== 0) begin
      tests_failed++; $display("FAIL basic_count: got %0d, required 0", dut.count);
    end
  endtask

  task automatic test_empty_stall();
    int stalled = 0;
    @(negedge clock); deq_req = 1'b1;
    @(negedge clock); deq_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (deq_busy === 1'b1) stalled++;
      @(negedge clock);
    end
    tests_run++;
    if (stalled !== 20) begin
      tests_failed++; $display("FAIL empty_stall: busy for %0d cycles, required 20", stalled);
    end
    enq_req = 1'b1; enq_in = 32'sh2A;
    @(negedge clock); enq_req = 1'b0;
    @(negedge clock);
    tests_run++;
    if (enq_busy !== 1'b0 || deq_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL empty_enque_first: enq_busy=%b deq_busy=%b, required 0 1", enq_busy, deq_busy);
    end
    @(negedge clock);
    tests_run++;
    if (deq_busy !== 1'b0 || deq_ret !== 32'sh2A) begin
      tests_failed++;
      $display("FAIL empty_deque_after: busy=%b ret=%h, required 0 0000002a", deq_busy, deq_ret);
    end
  endtask

  task automatic test_full_wrap();
    int cyc, stalled = 0;
    logic signed [DWIDTH-1:0] v, exp;
    for (int i = 0; i < DEPTH; i++) do_enque(i, cyc);
    @(negedge clock); enq_req = 1'b1; enq_in = 99;
    @(negedge clock); enq_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (enq_busy === 1'b1) stalled++;
      @(negedge clock);
    end
    tests_run++;
    if (stalled !== 5 || dut.count !== DEPTH) begin
      tests_failed++;
      $display("FAIL full_stall: busy %0d/5 count=%0d, required 5 and %0d", stalled, dut.count, DEPTH);
    end
    deq_req = 1'b1;
    @(negedge clock); deq_req = 1'b0;
    @(negedge clock);
    exp = model_q.pop_front();
    tests_run++;
    if (deq_busy !== 1'b0 || deq_ret !== exp || enq_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_deque_first: deq_busy=%b ret=%0d enq_busy=%b, required 0 %0d 1",
               deq_busy, deq_ret, enq_busy, exp);
    end
    @(negedge clock);
    model_q.push_back(99);
    tests_run++;
    if (enq_busy !== 1'b0 || dut.count !== DEPTH) begin
      tests_failed++;
      $display("FAIL full_enque_next: busy=%b count=%0d, required 0 %0d", enq_busy, dut.count, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      do_deque(v, cyc);
      exp = model_q.pop_front();
      tests_run++;
      if (v !== exp || cyc !== 1) begin
        tests_failed++; $display("FAIL wrap_drain[%0d]: got %0d, required %0d", i, v, exp);
      end
    end
  endtask

  task automatic test_finished();
    int cyc;
    logic r;
    logic vals[3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      if (i > 0) do_set_finished(vals[i], cyc);
      do_check_finished(r, cyc);
      tests_run++;
      if (r !== model_flag || cyc !== 1) begin
        tests_failed++;
        $display("FAIL finished[%0d]: got %b (%0d cycles), required %b", i, r, cyc, model_flag);
      end
    end
  endtask

  task automatic test_ce_hold();
    int held = 0;
    logic [AWIDTH:0] cnt0;
    cnt0 = dut.count;
    @(negedge clock); enq_req = 1'b1; enq_in = 32'sh1234;
    @(negedge clock); enq_req = 1'b0; ce = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (enq_busy === 1'b1 && dut.count === cnt0) held++;
    end
    tests_run++;
    if (held !== 10) begin
      tests_failed++; $display("FAIL ce_hold: frozen %0d of 10 cycles, required 10", held);
    end
    ce = 1'b1;
    @(negedge clock);
    model_q.push_back(32'sh1234);
    tests_run++;
    if (enq_busy !== 1'b0 || dut.count !== cnt0 + 1'b1) begin
      tests_failed++;
      $display("FAIL ce_resume: busy=%b count=%0d, required 0 %0d", enq_busy, dut.count, cnt0 + 1);
    end
  endtask

  task automatic test_random();
    int cyc;
    logic signed [DWIDTH-1:0] v, exp;
    logic r, f;
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 3))
        0: if (model_q.size() < DEPTH) do_enque($urandom, cyc);
        1: if (model_q.size() > 0) begin
          do_deque(v, cyc);
          exp = model_q.pop_front();
          tests_run++;
          if (v !== exp) begin
            tests_failed++; $display("FAIL rand_deque[%0d]: got %h, required %h", n, v, exp);
          end
        end
        2: begin f = 1'($urandom_range(0, 1)); do_set_finished(f, cyc); end
        default: begin
          do_check_finished(r, cyc);
          tests_run++;
          if (r !== model_flag) begin
            tests_failed++; $display("FAIL rand_check[%0d]: got %b, required %b", n, r, model_flag);
          end
        end
      endcase
    end
    tests_run++;
    if (dut.count !== model_q.size()) begin
      tests_failed++;
      $display("FAIL rand_count: got %0d, required %0d", dut.count, model_q.size());
    end
    while (model_q.size() > 0) begin
      do_deque(v, cyc);
      exp = model_q.pop_front();
      tests_run++;
      if (v !== exp) begin
        tests_failed++; $display("FAIL rand_drain: got %h, required %h", v, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    logic signed [DWIDTH-1:0] v;
    logic r;
    do_set_finished(1'b1, cyc);
    do_check_finished(r, cyc);
    @(negedge clock); deq_req = 1'b1;
    @(negedge clock); deq_req = 1'b0;
    repeat (3) @(negedge clock);
    tests_run++;
    if (deq_busy !== 1'b1 || chk_ret !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset: deq_busy=%b chk_ret=%b, required 1 1", deq_busy, chk_ret);
    end
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if ({enq_busy, deq_busy, isf_busy, chk_busy, chk_ret} !== 5'b0 || deq_ret !== '0 ||
        dut.count !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: busy=%b%b%b%b chk_ret=%b ret=%0d count=%0d, required all 0",
               enq_busy, deq_busy, isf_busy, chk_busy, chk_ret, deq_ret, dut.count);
    end
    @(negedge clock); reset_n = 1'b1;
    model_q.delete();
    model_flag = 1'b0;
    do_enque(-1, cyc);
    do_deque(v, cyc);
    tests_run++;
    if (v !== 32'hFFFF_FFFF || cyc !== 1) begin
      tests_failed++;
      $display("FAIL post_reset_neg1: got %h (%0d cycles), required ffffffff", v, cyc);
    end
    do_check_finished(r, cyc);
    tests_run++;
    if (r !== model_flag) begin
      tests_failed++; $display("FAIL post_reset_flag: got %b, required %b", r, model_flag);
    end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    test_reset();
    reset_n = 1'b1;
    test_basic();
    test_empty_stall();
    test_full_wrap();
    test_finished();
    test_ce_hold();
    test_random();
    test_async_reset();
    repeat (2) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
